// File: rtl/iic_mcp4725_slave.sv
// MCP4725-style I2C DAC slave.
// The block oversamples SCL/SDA on CLOCK and never stretches the clock.
// SDA is only ever pulled low or released, so the bus stays open-drain.
// Write pairs (high byte, low byte) commit a 12-bit DAC code and PD bits.
// Reads return a repeating three-byte status/code sequence.
module iic_mcp4725_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [11:0] oDacData,
  output logic [1:0]  oPowerDown,
  output logic        oUpdate,
  output logic        oBusy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, ACK_RD
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] shreg;     // incoming bits, MSB first
  logic [7:0] hi_byte;   // C2:C1, PD1:PD0, D11:D8
  logic [7:0] lo_byte;   // D7:D0
  logic [7:0] tx;        // outgoing bits, MSB in [7]
  logic [3:0] bitcnt;
  logic       byte_lo;   // 0: next write byte is the high byte
  logic       rw;
  logic       mack;      // master acknowledged the last read byte
  logic [1:0] rd_idx;    // which read byte is loaded next
  logic [7:0] rd_data;
  logic [1:0] rd_idx_nxt;

  // Open-drain: pull low or float, never drive high.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus a previous-value stage for edge strobes.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign sda_in    = sda_sync[1];
  assign scl_rise  =  scl_sync[1] & ~scl_prev;
  assign scl_fall  = ~scl_sync[1] &  scl_prev;
  assign sda_rise  =  sda_sync[1] & ~sda_prev;
  assign sda_fall  = ~sda_sync[1] &  sda_prev;
  // SCL must be high in both samples so an SCL edge coinciding with an
  // SDA edge is never mistaken for a bus condition.
  assign start_det = sda_fall & scl_sync[1] & scl_prev;
  assign stop_det  = sda_rise & scl_sync[1] & scl_prev;

  // Read byte selected by rd_idx; status byte reports RDY=1, POR=1.
  always_comb begin
    rd_data = 8'h00;
    case (rd_idx)
      2'd0:    rd_data = {2'b11, 3'b000, oPowerDown, 1'b0};
      2'd1:    rd_data = oDacData[11:4];
      default: rd_data = {oDacData[3:0], 4'h0};
    endcase
    rd_idx_nxt = (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
  end

  // Protocol FSM; bus conditions override any bit activity.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      shreg      <= 8'h00;
      hi_byte    <= 8'h00;
      lo_byte    <= 8'h00;
      tx         <= 8'h00;
      bitcnt     <= 4'd0;
      byte_lo    <= 1'b0;
      rw         <= 1'b0;
      mack       <= 1'b0;
      rd_idx     <= 2'd0;
      oDacData   <= 12'd0;
      oPowerDown <= 2'b00;
      oUpdate    <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      oUpdate <= 1'b0;
      if (start_det) begin
        // Also covers repeated START; oBusy is left as is.
        state  <= ADDR;
        bitcnt <= 4'd0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        oBusy  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shreg  <= {shreg[6:0], sda_in};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              if (shreg[7:1] == DEV_ADDR) begin
                sda_oe  <= 1'b1;
                oBusy   <= 1'b1;
                rw      <= shreg[0];
                byte_lo <= 1'b0;
                rd_idx  <= 2'd0;
                state   <= ACK_ADDR;
              end else begin
                oBusy <= 1'b0;
                state <= IDLE;
              end
            end
          end

          ACK_ADDR: begin
            if (scl_fall) begin
              bitcnt <= (rw) ? 4'd1 : 4'd0;
              if (rw) begin
                // First data bit goes out on the edge that ends the ACK.
                sda_oe <= ~rd_data[7];
                tx     <= {rd_data[6:0], 1'b0};
                rd_idx <= rd_idx_nxt;
                state  <= RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_BYTE;
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shreg  <= {shreg[6:0], sda_in};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              // Only complete bytes are latched; a cut-off byte is dropped.
              if (byte_lo) lo_byte <= shreg;
              else         hi_byte <= shreg;
              sda_oe <= 1'b1;
              state  <= ACK_WR;
            end
          end

          ACK_WR: begin
            if (scl_rise && byte_lo && hi_byte[7:6] == 2'b00) begin
              oDacData   <= {hi_byte[3:0], lo_byte};
              oPowerDown <= hi_byte[5:4];
              oUpdate    <= 1'b1;
            end else if (scl_fall) begin
              sda_oe  <= 1'b0;
              byte_lo <= ~byte_lo;
              bitcnt  <= 4'd0;
              state   <= WR_BYTE;
            end
          end

          RD_BYTE: begin
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ACK_RD;
              end else begin
                sda_oe <= ~tx[7];
                tx     <= {tx[6:0], 1'b0};
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          ACK_RD: begin
            if (scl_rise) begin
              mack <= ~sda_in;
            end else if (scl_fall) begin
              if (mack) begin
                sda_oe <= ~rd_data[7];
                tx     <= {rd_data[6:0], 1'b0};
                rd_idx <= rd_idx_nxt;
                bitcnt <= 4'd1;
                state  <= RD_BYTE;
              end else begin
                // NACK: stay off the bus until STOP or START.
                sda_oe <= 1'b0;
                state  <= IDLE;
              end
            end
          end

          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_mcp4725_slave.sv
// Bench for iic_mcp4725_slave: bit-banged I2C master, directed write table,
// hand-written corner sequences and randomized transactions against a model.
module tb_iic_mcp4725_slave;

  localparam int Q = 6;  // CLOCK cycles per quarter SCL period (24x)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_oe = 1'b0;
  wire         sda_bus;
  logic [11:0] dac;
  logic [1:0]  pd;
  logic        upd;
  logic        busy;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  iic_mcp4725_slave #(.DEV_ADDR(7'h60)) dut (
    .CLOCK(clk), .RESET(rst_n), .SCL(scl), .SDA(sda_bus),
    .oDacData(dac), .oPowerDown(pd), .oUpdate(upd), .oBusy(busy)
  );

  always #5 clk = ~clk;

  // Bus monitors: update pulses, over-long pulses, slave pulling SDA low.
  int   upd_cnt = 0, long_pulse = 0, slave_drv = 0;
  logic upd_q = 1'b0;
  always @(negedge clk) begin
    if (upd) upd_cnt++;
    if (upd && upd_q) long_pulse++;
    upd_q = upd;
    if (!m_sda_oe && sda_bus === 1'b0) slave_drv++;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: DAC state follows complete (high, low) pairs.
  logic [11:0] m_dac = 12'd0;
  logic [1:0]  m_pd  = 2'b00;
  int          m_upd = 0;

  function automatic void model_write(input logic [3:0][7:0] d, input int nb);
    for (int k = 0; k + 1 < nb; k += 2)
      if (d[k][7:6] == 2'b00) begin
        m_dac = {d[k][3:0], d[k+1]};
        m_pd  = d[k][5:4];
        m_upd++;
      end
  endfunction

  function automatic logic [7:0] model_read(input int k);
    case (k % 3)
      0:       return {2'b11, 3'b000, m_pd, 1'b0};
      1:       return m_dac[11:4];
      default: return {m_dac[3:0], 4'h0};
    endcase
  endfunction

  // Master bit-level primitives.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    m_sda_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    m_sda_oe = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda_oe = 1'b0; tick(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda_oe = ~b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~mack, s);
  endtask

  // Full write transaction; acks expected only for our address with R/W=0.
  task automatic do_write(input string tag, input logic [7:0] addr, input int nb,
                          input logic [3:0][7:0] d);
    logic ack, match;
    int   drv0;
    match = (addr[7:1] == 7'h60) && !addr[0];
    i2c_start();
    drv0 = slave_drv;
    write_byte(addr, ack);
    chk({tag, " addr-ack"}, ack, match);
    chk({tag, " busy"}, busy, match);
    for (int k = 0; k < nb; k++) begin
      write_byte(d[k], ack);
      chk({tag, " data-ack"}, ack, match);
    end
    i2c_stop(); tick(4);
    if (!match) chk({tag, " sda-undriven"}, slave_drv - drv0, 0);
    if (match) model_write(d, nb);
    chk({tag, " busy-after-stop"}, busy, 1'b0);
  endtask

  // Read transaction of nb bytes, last one NACKed; bytes checked against model.
  task automatic do_read(input string tag, input int nb, output logic [3:0][7:0] got);
    logic ack;
    logic [7:0] b;
    got = '0;
    i2c_start();
    write_byte(8'hC1, ack);
    chk({tag, " addr-ack"}, ack, 1'b1);
    for (int k = 0; k < nb; k++) begin
      read_byte(k < nb - 1, b);
      got[k] = b;
      chk({tag, " data"}, b, model_read(k));
    end
    i2c_stop(); tick(4);
    chk({tag, " busy-after-stop"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0]      addr;
    int              nb;
    logic [3:0][7:0] d;      // d[0] is sent first
    logic [11:0]     dac;
    logic [1:0]      pd;
    int              upd;
  } wvec_t;

  wvec_t tbl [6];

  initial begin
    logic [3:0][7:0] got;
    logic [3:0][7:0] d;
    logic [7:0]      b;
    logic            a, s;
    int              u0;

    tbl[0] = '{8'hC0, 2, {8'h00, 8'h00, 8'hF0, 8'h0F}, 12'hFF0, 2'b00, 1};
    tbl[1] = '{8'hC2, 2, {8'h00, 8'h00, 8'hF0, 8'h0F}, 12'hFF0, 2'b00, 0};
    tbl[2] = '{8'hC0, 1, {8'h00, 8'h00, 8'h00, 8'h3A}, 12'hFF0, 2'b00, 0};
    tbl[3] = '{8'hC0, 3, {8'h00, 8'h2F, 8'h67, 8'h15}, 12'h567, 2'b01, 1};
    tbl[4] = '{8'hC0, 2, {8'h00, 8'h00, 8'h11, 8'hC0}, 12'h567, 2'b01, 0};
    tbl[5] = '{8'hC0, 4, {8'h23, 8'h01, 8'hBC, 8'h2A}, 12'h123, 2'b00, 2};

    // Reset state
    tick(5);
    chk("reset dac", dac, 12'd0);
    chk("reset pd", pd, 2'b00);
    chk("reset upd", upd, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset sda", sda_bus, 1'b1);
    rst_n = 1'b1; tick(5);

    // Directed write table
    for (int i = 0; i < 6; i++) begin
      u0 = upd_cnt;
      do_write($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].nb, tbl[i].d);
      chk($sformatf("tbl%0d dac", i), dac, tbl[i].dac);
      chk($sformatf("tbl%0d pd", i), pd, tbl[i].pd);
      chk($sformatf("tbl%0d upd", i), upd_cnt - u0, tbl[i].upd);
    end

    // Read-back of 0xFF0 with ACK, ACK, NACK
    do_write("rb-prep", 8'hC0, 2, {8'h00, 8'h00, 8'hF0, 8'h0F});
    do_read("readback", 3, got);
    chk("readback b0", got[0], 8'hC0);
    chk("readback b1", got[1], 8'hFF);
    chk("readback b2", got[2], 8'h00);

    // Power-down write, repeated START, single-byte read
    u0 = upd_cnt;
    i2c_start();
    write_byte(8'hC0, a); chk("rs addr-ack", a, 1'b1);
    write_byte(8'h2A, a); chk("rs hi-ack", a, 1'b1);
    write_byte(8'hBC, a); chk("rs lo-ack", a, 1'b1);
    i2c_rstart();
    chk("rs busy-held", busy, 1'b1);
    write_byte(8'hC1, a); chk("rs raddr-ack", a, 1'b1);
    read_byte(1'b0, b);   chk("rs status", b, 8'hC4);
    i2c_stop(); tick(4);
    chk("rs dac", dac, 12'hABC);
    chk("rs pd", pd, 2'b10);
    chk("rs upd", upd_cnt - u0, 1);
    m_dac = 12'hABC; m_pd = 2'b10; m_upd++;

    // Ignored command pair, then a high byte and a cut-off low byte
    u0 = upd_cnt;
    i2c_start();
    write_byte(8'hC0, a); chk("ign addr-ack", a, 1'b1);
    write_byte(8'h4A, a); chk("ign hi-ack", a, 1'b1);
    write_byte(8'hBC, a); chk("ign lo-ack", a, 1'b1);
    write_byte(8'h01, a); chk("ign hi2-ack", a, 1'b1);
    clock_bit(1'b0, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
    i2c_stop(); tick(4);
    chk("ign dac", dac, 12'hABC);
    chk("ign pd", pd, 2'b10);
    chk("ign upd", upd_cnt - u0, 0);

    // Reset in the middle of the first data byte
    i2c_start();
    write_byte(8'hC0, a); chk("rst addr-ack", a, 1'b1);
    clock_bit(1'b0, s); clock_bit(1'b0, s); clock_bit(1'b0, s); clock_bit(1'b0, s);
    m_sda_oe = 1'b0;
    rst_n = 1'b0; tick(3);
    chk("rst dac", dac, 12'd0);
    chk("rst pd", pd, 2'b00);
    chk("rst upd", upd, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst sda", sda_bus, 1'b1);
    scl = 1'b1; tick(Q);
    rst_n = 1'b1; tick(Q);
    m_dac = 12'd0; m_pd = 2'b00;
    u0 = upd_cnt;
    do_write("post-rst", 8'hC0, 2, {8'h00, 8'h00, 8'hF0, 8'h0F});
    chk("post-rst dac", dac, 12'hFF0);
    chk("post-rst upd", upd_cnt - u0, 1);

    // Randomized traffic against the model
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_read($sformatf("rnd%0d rd", t), int'($urandom_range(1, 4)), got);
      end else begin
        logic [6:0] a7;
        int nb;
        a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h60;
        nb = int'($urandom_range(1, 4));
        for (int k = 0; k < 4; k++) begin
          d[k] = 8'($urandom);
          if ($urandom_range(0, 3) != 0) d[k][7:6] = 2'b00;
        end
        do_write($sformatf("rnd%0d wr", t), {a7, 1'b0}, nb, d);
      end
      chk($sformatf("rnd%0d dac", t), dac, m_dac);
      chk($sformatf("rnd%0d pd", t), pd, m_pd);
      chk($sformatf("rnd%0d upd", t), upd_cnt, m_upd);
    end

    chk("update pulse width", long_pulse, 0);
    chk("update total", upd_cnt, m_upd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
